// File: rtl/regfile_writeback_unit.sv
// regfile_writeback_unit
// Write-port sequencer for the 32x32 register file. Load and ALU results are
// queued in program order (load before ALU when both arrive together) and
// drained one write per cycle through a registered waddr/wdata/we stage.
// Decode can ask whether a register still has a write pending, and execute
// is told to hold off while the queue is nearly full.
module regfile_writeback_unit #(
    parameter int DEPTH      = 4,
    parameter bit DISCARD_R0 = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        stall,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        we,
    input  logic [4:0]  qaddr1,
    input  logic [4:0]  qaddr2,
    output logic        busy1,
    output logic        busy2,
    output logic        overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]    rdMem   [DEPTH];
    logic [31:0]   dataMem [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] count;

    logic          ldV;
    logic          aluV;
    logic          ldAcc;
    logic          aluAcc;
    logic          pop;
    logic [CW-1:0] freeSlots;
    logic [CW-1:0] nextCount;
    logic [4:0]    headRd;
    logic [31:0]   headData;
    logic [DEPTH-1:0] entryValid;

    // Filter r0 writes, decide which pushes fit, and pick the entry to drain.
    // A slot counts as free if the head is leaving this cycle; when the queue
    // is empty the first accepted push bypasses straight to the output stage.
    always_comb begin
        ldV       = ld_valid && !(DISCARD_R0 && (ld_rd == 5'd0));
        aluV      = alu_valid && !(DISCARD_R0 && (alu_rd == 5'd0));
        freeSlots = CW'(DEPTH) - count + ((count != '0) ? CW'(1) : CW'(0));
        ldAcc     = ldV && (freeSlots >= CW'(1));
        aluAcc    = aluV && (freeSlots >= (ldAcc ? CW'(2) : CW'(1)));
        pop       = (count != '0) || ldAcc || aluAcc;
        nextCount = count + CW'(ldAcc) + CW'(aluAcc) - CW'(pop);
        if (count != '0) begin
            headRd   = rdMem[rdPtr];
            headData = dataMem[rdPtr];
        end else if (ldAcc) begin
            headRd   = ld_rd;
            headData = ld_data;
        end else begin
            headRd   = alu_rd;
            headData = alu_data;
        end
    end

    // Queue storage: load lands at the write pointer, ALU entry right behind it.
    always_ff @(posedge clk) begin
        if (ldAcc) begin
            rdMem[wrPtr]   <= ld_rd;
            dataMem[wrPtr] <= ld_data;
        end
        if (aluAcc) begin
            rdMem[wrPtr + PW'(ldAcc)]   <= alu_rd;
            dataMem[wrPtr + PW'(ldAcc)] <= alu_data;
        end
    end

    // Pointers, occupancy, output write stage, stall and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            we       <= 1'b0;
            waddr    <= 5'd0;
            wdata    <= 32'd0;
            stall    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wrPtr <= wrPtr + PW'(ldAcc) + PW'(aluAcc);
            rdPtr <= rdPtr + PW'(pop);
            count <= nextCount;
            we    <= pop;
            if (pop) begin
                waddr <= headRd;
                wdata <= headData;
            end
            stall    <= (nextCount >= CW'(DEPTH - 2));
            overflow <= overflow || (ldV && !ldAcc) || (aluV && !aluAcc);
        end
    end

    // Mark which physical slots hold live entries (distance from head < count).
    always_comb begin : slotValid
        logic [PW-1:0] offs;
        entryValid = '0;
        offs       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs          = PW'(i) - rdPtr;
            entryValid[i] = (CW'(offs) < count);
        end
    end

    // Pending-write lookup for decode: live queue entries plus the output stage.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (!(DISCARD_R0 && (qaddr1 == 5'd0))) begin
            busy1 = we && (waddr == qaddr1);
            for (int i = 0; i < DEPTH; i++) begin
                if (entryValid[i] && (rdMem[i] == qaddr1)) begin
                    busy1 = 1'b1;
                end
            end
        end
        if (!(DISCARD_R0 && (qaddr2 == 5'd0))) begin
            busy2 = we && (waddr == qaddr2);
            for (int i = 0; i < DEPTH; i++) begin
                if (entryValid[i] && (rdMem[i] == qaddr2)) begin
                    busy2 = 1'b1;
                end
            end
        end
    end

endmodule
